// File: rtl/wots_pkg.sv
// wots_pkg: shared mode/state encodings and XMSS hash-address field helpers
// Address layout: 8 x 32-bit words, word 0 in bits [255:224], word 7 in bits [31:0].
package wots_pkg;
  typedef enum logic [1:0] {MODE_GEN_PK = 2'd0, MODE_SIGN = 2'd1, MODE_VERIFY = 2'd2, MODE_RSVD = 2'd3} mode_t;
  typedef enum logic [2:0] {IDLE, READ, READ_WAIT, LAUNCH, WAIT_CHAIN, WRITE, FINISH} state_t;
  localparam int CHAIN_WORD = 5;
  localparam int HASH_WORD = 6;
  function automatic logic [255:0] set_word(input logic [255:0] a, input int w, input logic [31:0] v);
    logic [255:0] r;
    r = a;
    r[(7 - w) * 32 +: 32] = v;
    return r;
  endfunction
  function automatic logic [255:0] set_chain(input logic [255:0] a, input logic [31:0] v);
    return set_word(a, CHAIN_WORD, v);
  endfunction
  function automatic logic [255:0] set_hash(input logic [255:0] a, input logic [31:0] v);
    return set_word(a, HASH_WORD, v);
  endfunction
endpackage

// File: rtl/wots_chain_sched_if.sv
// wots_chain_sched_if: key-memory port and gen_chain engine handshake
// master = scheduler side, slave = memory/engine side.
interface wots_chain_sched_if #(
  parameter int KEY_LEN = 256,
  parameter int ADDR_W = 7,
  parameter int LOG_W = 4
);
  logic mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [KEY_LEN-1:0] mem_rd_data;
  logic mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [KEY_LEN-1:0] mem_wr_data;
  logic chain_start;
  logic [KEY_LEN-1:0] chain_data_in;
  logic [LOG_W-1:0] chain_start_step;
  logic [LOG_W-1:0] chain_end_step;
  logic [255:0] chain_hash_addr;
  logic [KEY_LEN-1:0] chain_data_out;
  logic chain_done;
  logic [255:0] chain_hash_addr_updated;
  modport master(
    output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    output chain_start, chain_data_in, chain_start_step, chain_end_step, chain_hash_addr,
    input mem_rd_data, chain_data_out, chain_done, chain_hash_addr_updated
  );
  modport slave(
    input mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    input chain_start, chain_data_in, chain_start_step, chain_end_step, chain_hash_addr,
    output mem_rd_data, chain_data_out, chain_done, chain_hash_addr_updated
  );
endinterface

// File: rtl/wots_step_calc.sv
// wots_step_calc: maps (mode, base-w digit) to chain start/end steps and a zero-length skip flag
// Ports: mode, digit in; start_step, end_step, skip out (combinational).
module wots_step_calc
  import wots_pkg::*;
#(
  parameter int WOTS_W = 16,
  parameter int LOG_W = $clog2(WOTS_W)
) (
  input  mode_t            mode,
  input  logic [LOG_W-1:0] digit,
  output logic [LOG_W-1:0] start_step,
  output logic [LOG_W-1:0] end_step,
  output logic             skip
);
  localparam logic [LOG_W-1:0] MAX_STEP = LOG_W'(WOTS_W - 1);
  always_comb begin
    start_step = mode == MODE_VERIFY ? digit : '0;
    end_step = mode == MODE_SIGN ? digit : MAX_STEP;
    skip = start_step == end_step;
  end
endmodule

// File: rtl/wots_chain_sched.sv
// wots_chain_sched: walks all WOTS chains (GEN_PK/SIGN/VERIFY) through one external gen_chain engine
// Ports: start/mode/abort/msg_digits/hash_addr control in; busy/done/hash_addr_out status out;
// bus carries the key-memory read/write port and the gen_chain start/done handshake.
module wots_chain_sched
  import wots_pkg::*;
#(
  parameter int WOTS_W = 16,
  parameter int WOTS_LEN = 67,
  parameter int KEY_LEN = 256,
  parameter int WOTS_LOG_W = $clog2(WOTS_W),
  parameter int ADDR_W = $clog2(WOTS_LEN)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [1:0]                     mode,
  input  logic                           abort,
  input  logic [WOTS_LEN*WOTS_LOG_W-1:0] msg_digits,
  input  logic [255:0]                   hash_addr,
  output logic                           busy,
  output logic                           done,
  output logic [255:0]                   hash_addr_out,
  wots_chain_sched_if.master             bus
);
  state_t state, nxt;
  mode_t mode_q;
  logic [ADDR_W-1:0] idx;
  logic [WOTS_LEN*WOTS_LOG_W-1:0] dig_q;
  logic [255:0] addr_q, chain_addr_q;
  logic [KEY_LEN-1:0] data_q;
  logic [WOTS_LOG_W-1:0] st_q, en_q, s, e;
  logic skip, last;
  assign last = idx == ADDR_W'(WOTS_LEN - 1);
  wots_step_calc #(.WOTS_W(WOTS_W), .LOG_W(WOTS_LOG_W)) u_step (
    .mode(mode_q),
    .digit(dig_q[int'(idx) * WOTS_LOG_W +: WOTS_LOG_W]),
    .start_step(s),
    .end_step(e),
    .skip(skip)
  );
  // data_q holds the read element, then the engine result; it feeds both chain_data_in and the write-back
  assign bus.mem_rd_addr = idx;
  assign bus.mem_wr_addr = idx;
  assign bus.mem_wr_data = data_q;
  assign bus.chain_data_in = data_q;
  assign bus.chain_start_step = st_q;
  assign bus.chain_end_step = en_q;
  assign bus.chain_hash_addr = chain_addr_q;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:       nxt = start ? READ : IDLE;
      READ:       nxt = READ_WAIT;
      READ_WAIT:  nxt = skip ? WRITE : LAUNCH;
      LAUNCH:     nxt = WAIT_CHAIN;
      WAIT_CHAIN: nxt = bus.chain_done ? WRITE : WAIT_CHAIN;
      WRITE:      nxt = last ? FINISH : READ;
      FINISH:     nxt = IDLE;
      default:    nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
    busy = state != IDLE;
    done = state == FINISH && !abort;
    bus.mem_rd_en = state == READ && !abort;
    bus.mem_wr_en = state == WRITE && !abort;
    bus.chain_start = state == LAUNCH && !abort;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      mode_q <= MODE_GEN_PK;
      idx <= '0;
      dig_q <= '0;
      addr_q <= '0;
      chain_addr_q <= '0;
      data_q <= '0;
      st_q <= '0;
      en_q <= '0;
      hash_addr_out <= '0;
    end else begin
      state <= nxt;
      if (!abort) begin
        if (state == IDLE && start) begin
          mode_q <= mode == MODE_RSVD ? MODE_GEN_PK : mode_t'(mode);
          dig_q <= msg_digits;
          addr_q <= hash_addr;
          idx <= '0;
        end
        if (state == READ_WAIT) begin
          data_q <= bus.mem_rd_data;
          st_q <= s;
          en_q <= e;
          chain_addr_q <= set_hash(set_chain(addr_q, 32'(idx)), 32'(s));
        end
        if (state == WAIT_CHAIN && bus.chain_done) begin
          data_q <= bus.chain_data_out;
          addr_q <= bus.chain_hash_addr_updated;
        end
        if (state == WRITE) begin
          idx <= idx + 1'b1;
          if (last) hash_addr_out <= set_hash(set_chain(addr_q, 32'(WOTS_LEN - 1)), '0);
        end
      end
    end
endmodule

// File: tb/tb_wots_chain_sched.sv
// tb_wots_chain_sched: scoreboard bench with memory/engine models and a spec-level reference model
module tb_wots_chain_sched;
  localparam int W = 16, LEN = 67, KL = 256, LW = 4, AW = 7;
  logic clk = 0, reset = 0, start = 0, abort = 0;
  logic [1:0] mode = 0;
  logic [LEN*LW-1:0] msg_digits = '0;
  logic [255:0] hash_addr = '0;
  logic busy, done;
  logic [255:0] hash_addr_out;
  wots_chain_sched_if #(.KEY_LEN(KL), .ADDR_W(AW), .LOG_W(LW)) bus();
  wots_chain_sched #(.WOTS_W(W), .WOTS_LEN(LEN), .KEY_LEN(KL)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .abort(abort),
    .msg_digits(msg_digits), .hash_addr(hash_addr), .busy(busy), .done(done),
    .hash_addr_out(hash_addr_out), .bus(bus)
  );
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  function automatic void chk(input bit ok, input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction
  function automatic logic [255:0] put_word(input logic [255:0] a, input int w, input logic [31:0] v);
    logic [255:0] r;
    r = a;
    r[(7 - w) * 32 +: 32] = v;
    return r;
  endfunction
  function automatic logic [31:0] get_word(input logic [255:0] a, input int w);
    return a[(7 - w) * 32 +: 32];
  endfunction
  // stand-in for the hash chain: one arithmetic round per step, position dependent
  function automatic logic [255:0] chain_fn(input logic [255:0] x, input int s, input int e, input int i);
    logic [255:0] r;
    r = x;
    for (int st = s; st < e; st++) r = r * 256'd5 + 256'(st * 131 + i);
    return r;
  endfunction
  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction
  function automatic int nz_outs();
    return int'(busy) + int'(done) + int'(|hash_addr_out) + int'(bus.mem_rd_en) + int'(|bus.mem_rd_addr)
      + int'(bus.mem_wr_en) + int'(|bus.mem_wr_addr) + int'(|bus.mem_wr_data) + int'(bus.chain_start)
      + int'(|bus.chain_data_in) + int'(|bus.chain_start_step) + int'(|bus.chain_end_step) + int'(|bus.chain_hash_addr);
  endfunction

  // key memory: 1-cycle read latency, bulk load from init_mem
  logic [KL-1:0] mem [LEN];
  logic [KL-1:0] init_mem [LEN];
  logic load = 0;
  always @(posedge clk) begin
    if (load) mem <= init_mem;
    else if (bus.mem_wr_en) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
  end

  // gen_chain engine: done pulses tc cycles after the start cycle
  int tc = 15;
  logic eng_done = 0, spur_done = 0;
  logic [255:0] e_res, e_addr;
  assign bus.chain_done = eng_done | spur_done;
  initial begin
    bus.chain_data_out = '0;
    bus.chain_hash_addr_updated = '0;
    forever begin
      @(negedge clk);
      if (bus.chain_start) begin
        e_res = chain_fn(bus.chain_data_in, int'(bus.chain_start_step), int'(bus.chain_end_step), int'(get_word(bus.chain_hash_addr, 5)));
        e_addr = put_word(bus.chain_hash_addr, 6, 32'(bus.chain_end_step));
        repeat (tc) @(posedge clk);
        #1 eng_done = 1;
        bus.chain_data_out = e_res;
        bus.chain_hash_addr_updated = e_addr;
        @(posedge clk);
        #1 eng_done = 0;
      end
    end
  end

  typedef struct {logic [255:0] din; int s; int e; int i;} cs_t;
  typedef struct {int a; logic [255:0] d;} wr_t;
  cs_t qs[$];
  wr_t qw[$];
  logic [255:0] qd[$];
  logic [255:0] cur_ha = '0;
  int cyc = 0, n_start = 0, n_done = 0, done_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: pops expectations whenever the DUT presents a strobe
  initial forever begin
    cs_t c;
    wr_t w;
    logic [255:0] h;
    @(negedge clk);
    if (reset) begin
      if (bus.mem_rd_en || bus.mem_wr_en) chk(!(bus.mem_rd_en && bus.mem_wr_en), "rd_wr_exclusive", 1, 0);
      if (bus.chain_start) begin
        n_start++;
        if (qs.size() == 0) chk(0, "chain_start_unexpected", 1, 0);
        else begin
          c = qs.pop_front();
          chk(bus.chain_data_in == c.din, "chain_data_in", bus.chain_data_in, c.din);
          chk(int'(bus.chain_start_step) == c.s, "chain_start_step", bus.chain_start_step, c.s);
          chk(int'(bus.chain_end_step) == c.e, "chain_end_step", bus.chain_end_step, c.e);
          h = put_word(put_word(cur_ha, 5, c.i), 6, c.s);
          chk(bus.chain_hash_addr == h, "chain_hash_addr", bus.chain_hash_addr, h);
        end
      end
      if (bus.mem_wr_en) begin
        if (qw.size() == 0) chk(0, "mem_wr_unexpected", bus.mem_wr_addr, 0);
        else begin
          w = qw.pop_front();
          chk(int'(bus.mem_wr_addr) == w.a, "mem_wr_addr", bus.mem_wr_addr, w.a);
          chk(bus.mem_wr_data == w.d, "mem_wr_data", bus.mem_wr_data, w.d);
        end
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        if (qd.size() == 0) chk(0, "done_unexpected", 1, 0);
        else begin
          h = qd.pop_front();
          chk(hash_addr_out == h, "hash_addr_out", hash_addr_out, h);
        end
      end
    end
  end

  task automatic load_mem();
    for (int i = 0; i < LEN; i++) init_mem[i] = rnd256();
    @(posedge clk);
    #1 load = 1;
    @(posedge clk);
    #1 load = 0;
  endtask

  task automatic run(input int md, input logic [LEN*LW-1:0] dg, input int lat, input bit poke);
    int total, c0, s, e, d, b_start, b_done, exp_starts;
    bit ok;
    logic [KL-1:0] nm [LEN];
    logic [255:0] ha, fin;
    total = 1;
    exp_starts = 0;
    tc = lat;
    load_mem();
    ha = rnd256();
    cur_ha = ha;
    for (int i = 0; i < LEN; i++) begin
      d = int'(dg[i*LW +: LW]);
      s = md == 2 ? d : 0;
      e = md == 1 ? d : W - 1;
      if (s == e) begin
        total += 3;
        nm[i] = init_mem[i];
      end else begin
        total += 4 + lat;
        exp_starts++;
        qs.push_back('{init_mem[i], s, e, i});
        nm[i] = chain_fn(init_mem[i], s, e, i);
      end
      qw.push_back('{i, nm[i]});
    end
    fin = put_word(put_word(ha, 6, 0), 5, LEN - 1);
    qd.push_back(fin);
    b_start = n_start;
    b_done = n_done;
    mode = 2'(md);
    msg_digits = dg;
    hash_addr = ha;
    start = 1;
    c0 = cyc;
    @(posedge clk);
    #1 start = 0;
    mode = 2'($urandom);
    for (int j = 0; j < LEN; j++) msg_digits[j*LW +: LW] = LW'($urandom);
    hash_addr = rnd256();
    chk(busy, "busy_after_start", busy, 1);
    for (int k = 0; k < 6000 && n_done == b_done; k++) begin
      @(posedge clk);
      #1 start = poke && k == 20;
    end
    start = 0;
    chk(n_done != b_done, "done_timeout", 0, 1);
    chk(done_cyc - c0 == total, "done_latency", done_cyc - c0, total);
    repeat (5) @(posedge clk);
    #1;
    chk(n_done - b_done == 1, "done_count", n_done - b_done, 1);
    chk(n_start - b_start == exp_starts, "chain_start_count", n_start - b_start, exp_starts);
    chk(!busy, "busy_after_done", busy, 0);
    chk(qs.size() + qw.size() + qd.size() == 0, "queues_drained", qs.size() + qw.size() + qd.size(), 0);
    ok = 1;
    for (int i = 0; i < LEN; i++) if (mem[i] !== nm[i]) ok = 0;
    chk(ok, "mem_final", ok, 1);
    chk(hash_addr_out == fin, "hash_addr_out_hold", hash_addr_out, fin);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d expected=0", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [LEN*LW-1:0] dg;
    int b_done;
    bit found;
    repeat (2) @(posedge clk);
    #1 chk(nz_outs() == 0, "reset_outputs", nz_outs(), 0);
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    // GEN_PK, full-length chains with the slow engine
    for (int j = 0; j < LEN; j++) dg[j*LW +: LW] = LW'($urandom);
    run(0, dg, 15, 0);
    // SIGN with all-zero digits: every chain skipped, memory untouched
    run(1, '0, 3, 0);
    // VERIFY: only chain 0 is non-empty, from step 3
    dg = '1;
    dg[LW-1:0] = LW'(3);
    run(2, dg, 5, 0);
    // abort during WAIT_CHAIN of chain 10
    tc = 15;
    load_mem();
    cur_ha = rnd256();
    for (int i = 0; i <= 10; i++) begin
      qs.push_back('{init_mem[i], 0, W - 1, i});
      if (i < 10) qw.push_back('{i, chain_fn(init_mem[i], 0, W - 1, i)});
    end
    b_done = n_done;
    mode = 0;
    hash_addr = cur_ha;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int k = 0; k < 2000 && qs.size() != 0; k++) @(posedge clk);
    chk(qs.size() == 0, "abort_reach_chain10", qs.size(), 0);
    repeat (3) @(posedge clk);
    #1 abort = 1;
    start = 1;
    @(posedge clk);
    #1 abort = 0;
    start = 0;
    chk(!busy, "busy_after_abort", busy, 0);
    repeat (40) @(posedge clk);
    #1;
    chk(!busy, "idle_after_abort", busy, 0);
    chk(n_done == b_done, "no_done_after_abort", n_done - b_done, 0);
    chk(qw.size() == 0, "abort_writes_before", qw.size(), 0);
    // start together with abort in IDLE: abort wins
    abort = 1;
    start = 1;
    @(posedge clk);
    #1 abort = 0;
    start = 0;
    chk(!busy, "abort_beats_start", busy, 0);
    run(3, dg, 2, 0);
    // spurious chain_done in IDLE, then a run with a start pulse while busy
    spur_done = 1;
    @(posedge clk);
    #1 spur_done = 0;
    chk(!busy, "spurious_done_idle", busy, 0);
    for (int j = 0; j < LEN; j++) dg[j*LW +: LW] = LW'($urandom);
    run(1, dg, 2, 1);
    // asynchronous reset in READ_WAIT of chain 5
    load_mem();
    for (int i = 0; i < 5; i++) qw.push_back('{i, init_mem[i]});
    mode = 1;
    msg_digits = '0;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      found = bus.mem_rd_en && bus.mem_rd_addr == 5;
    end
    chk(found, "reset_reach_read5", found, 1);
    @(posedge clk);
    #1 reset = 0;
    #1 chk(nz_outs() == 0, "async_reset_outputs", nz_outs(), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 chk(!busy && !done, "idle_after_reset", {busy, done}, 0);
    chk(qw.size() == 0, "reset_writes_before", qw.size(), 0);
    // randomized runs across all modes
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < LEN; j++) dg[j*LW +: LW] = LW'($urandom);
      run(int'($urandom_range(0, 3)), dg, int'($urandom_range(1, 4)), r[0]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
